lcd_spi_shift_engine: RTL and testbench
=======================================

# lcd_spi_shift_engine

Parallel-to-serial SPI transmit engine for the round LCD gauges, sitting directly downstream of the 16x8 command/parameter FIFO and the 256x16 pixel FIFO. It arbitrates between the two, with byte traffic taking priority at word boundaries. It shifts each entry MSB-first onto lcd_data/lcd_sclk in SPI mode 0, and reports lcd_busy for the register interface. All logic runs in the 64 MHz mclk domain.

## Interface
- HALF_PERIOD, 2, mclk cycles per SCLK half-phase (2 gives 16 MHz SCLK); legal range 1..255.
- mclk  in  1  64 MHz clock.
- s00_axi_aresetn  in  1  reset, asynchronous, active-low.
- mclk_pll_locked  in  1  low forces a synchronous return to IDLE, with outputs at reset values.
- d8_empty  in  1  byte FIFO empty (first-word-fall-through).
- d8_data  in  8  byte FIFO head; valid while !d8_empty.
- d8_read  out  1  one-cycle pop of the byte FIFO.
- d16_empty  in  1  word FIFO empty (first-word-fall-through).
- d16_data  in  16  word FIFO head; valid while !d16_empty.
- d16_read  out  1  one-cycle pop of the word FIFO.
- lcd_busy  out  1  high from load until the last SCLK fall.
- lcd_sclk  out  1  SPI clock, idle low.
- lcd_data  out  1  SPI MOSI.

## Operation
- The state machine has three states: IDLE, LOW and HIGH. It uses a 16-bit shift register shreg, a 4-bit bitcnt and an 8-bit phase counter ph.
- Load rule, applied in IDLE and at the end of HIGH when bitcnt==0:
  - If !d8_empty: pulse d8_read, set shreg={d8_data,8'h00}, set bitcnt=7.
  - Else if !d16_empty: pulse d16_read, set shreg=d16_data, set bitcnt=15.
  - Else go to IDLE.
  - A successful load goes to LOW with ph=0.
- IDLE: lcd_sclk=0, lcd_busy=0, lcd_data holds its last value.
- LOW: lcd_data=shreg[15], lcd_sclk=0. When ph==HALF_PERIOD-1, go to HIGH with ph=0.
- HIGH: lcd_sclk=1. When ph==HALF_PERIOD-1, lcd_sclk falls.
  - If bitcnt!=0: shift shreg left by 1, decrement bitcnt, go to LOW.
  - Else apply the load rule.
- Byte priority is evaluated only at load points. A byte arriving mid-word never interrupts a word.
- At most one of d8_read and d16_read is high in any cycle. Neither is asserted while its FIFO is empty.
- Deasserting mclk_pll_locked mid-word aborts the word: go to IDLE, lcd_sclk=0, no pop. The partially sent word is lost.
- Async reset mid-word has the same effect.

## Timing
- Reset values: lcd_sclk=0, lcd_data=0, d8_read=0, d16_read=0, lcd_busy=0, state=IDLE.
- All outputs are registered.
- Latency: !empty seen in IDLE → read pulse plus load on the next edge → lcd_data valid and lcd_busy=1 on that same edge. The first SCLK rise follows HALF_PERIOD cycles later.
- Word length on the wire: 2*HALF_PERIOD*bits mclk cycles. That is 64 cycles for a 16-bit word and 32 for a byte at HALF_PERIOD=2.
- Back-to-back: the next word's MSB is driven on the same edge as the previous word's final SCLK fall, so there is no gap cycle.
- lcd_data changes only in the cycle SCLK falls or at load, and is stable across each rising edge (mode 0).
- lcd_busy drops in the cycle after the final SCLK fall, and only when both FIFOs are empty.

## Configuration
- LCD_SPI_BYTE_SWAP_EN
  - Defined: the word load uses {d16_data[7:0], d16_data[15:8]}, for little-endian RGB565 producers.
  - Undefined: d16_data is loaded unchanged.
- Byte loads are unaffected either way.

## Structure
- lcd_spi_pkg holds:
  - state enum (IDLE, LOW, HIGH);
  - BYTE_BITS=8 and WORD_BITS=16;
  - default HALF_PERIOD constant.
- Sub-module lcd_spi_sclk_gen contains the phase counter ph. It outputs a one-cycle phase_end strobe and takes a restart input. The engine owns all shift and arbitration state.

## Test plan
- Single byte 0xA5 in d8, d16 empty: one d8_read pulse, 8 SCLK rises, MOSI 1,0,1,0,0,1,0,1 sampled on the rises, lcd_busy high for 32 cycles.
- Words 0x1234 and 0xFFFF queued: two d16_read pulses 64 cycles apart, 32 rises with no gap, MOSI matches MSB-first. With LCD_SPI_BYTE_SWAP_EN, the first word shifts as 0x3412.
- Byte 0x2C arrives 10 cycles into word 0xF800: the word completes, then 0x2C shifts. d8_read coincides with the final fall of 0xF800.
- Both FIFOs non-empty in IDLE (d8 0x36, d16 0x0000): d8_read first, d16_read on the first HIGH-phase end after the 8th rise. The two reads are never asserted together.
- mclk_pll_locked dropped after 5 rises of 0xABCD: next cycle lcd_sclk=0, lcd_busy=0, no further reads. After relock with an empty FIFO, lcd_busy stays low.
- HALF_PERIOD=1 with 3 bytes queued: SCLK is 32 MHz, 24 rises in 48 cycles, three d8_read pulses 16 cycles apart.

Source files
------------

// File: rtl/lcd_spi_pkg.sv
// Shared types and constants for the LCD SPI transmit path.
package lcd_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam int BYTE_BITS           = 8;
    localparam int WORD_BITS           = 16;
    // 2 mclk cycles per half-phase gives a 16 MHz SCLK from the 64 MHz mclk.
    localparam int HALF_PERIOD_DEFAULT = 2;

endpackage

// File: rtl/lcd_spi_sclk_gen.sv
// SCLK half-phase timer: ph counts mclk cycles within one SCLK half-phase and
// phase_end_o strobes for one cycle on the last cycle of each half-phase.
module lcd_spi_sclk_gen #(
    parameter int HALF_PERIOD = 2
) (
    input  logic mclk,
    input  logic s00_axi_aresetn,
    input  logic restart_i,
    output logic phase_end_o
);

    logic [7:0] ph_q;

    // Held at zero while restarting so the first half-phase after a load is full length.
    assign phase_end_o = !restart_i && (ph_q == 8'(HALF_PERIOD - 1));

    // Phase counter wraps at the end of every half-phase.
    always_ff @(posedge mclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ph_q <= 8'd0;
        end else if (restart_i || phase_end_o) begin
            ph_q <= 8'd0;
        end else begin
            ph_q <= ph_q + 8'd1;
        end
    end

endmodule

// File: rtl/lcd_spi_shift_engine.sv
// Parallel-to-serial SPI (mode 0) transmit engine fed by the byte and word FIFOs.
// Byte FIFO wins arbitration, but only at load points, so words are never cut.
// Optional build macro: LCD_SPI_BYTE_SWAP_EN swaps the two bytes of each word load.
module lcd_spi_shift_engine
    import lcd_spi_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
    input  logic        mclk,
    input  logic        s00_axi_aresetn,
    input  logic        mclk_pll_locked,
    input  logic        d8_empty,
    input  logic [7:0]  d8_data,
    output logic        d8_read,
    input  logic        d16_empty,
    input  logic [15:0] d16_data,
    output logic        d16_read,
    output logic        lcd_busy,
    output logic        lcd_sclk,
    output logic        lcd_data
);

    state_t      state_q;
    logic [15:0] shreg_q;
    logic [3:0]  bitcnt_q;
    logic        sclk_q, data_q, busy_q, rd8_q, rd16_q;
    logic [15:0] word_d;
    logic        phase_end, restart, load_pt;

    // Word as it goes onto the wire; swapped variant serves little-endian RGB565 sources.
    always_comb begin
        word_d = d16_data;
`ifdef LCD_SPI_BYTE_SWAP_EN
        word_d = {d16_data[7:0], d16_data[15:8]};
`endif
    end

    assign restart = (state_q == IDLE) || !mclk_pll_locked;
    // Loads happen from IDLE and on the final SCLK fall of an entry, giving gapless back-to-back.
    assign load_pt = (state_q == IDLE) || ((state_q == HIGH) && phase_end && (bitcnt_q == 4'd0));

    lcd_spi_sclk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_sclk_gen (
        .mclk            (mclk),
        .s00_axi_aresetn (s00_axi_aresetn),
        .restart_i       (restart),
        .phase_end_o     (phase_end)
    );

    // Transmit FSM with registered SPI, busy and FIFO pop outputs.
    always_ff @(posedge mclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q  <= IDLE;
            shreg_q  <= 16'h0000;
            bitcnt_q <= 4'd0;
            sclk_q   <= 1'b0;
            data_q   <= 1'b0;
            busy_q   <= 1'b0;
            rd8_q    <= 1'b0;
            rd16_q   <= 1'b0;
        end else begin
            rd8_q  <= 1'b0;
            rd16_q <= 1'b0;
            if (!mclk_pll_locked) begin
                // Losing the clock source drops any partial entry; nothing is popped.
                state_q <= IDLE;
                sclk_q  <= 1'b0;
                data_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    LOW: if (phase_end) begin
                        state_q <= HIGH;
                        sclk_q  <= 1'b1;
                    end
                    HIGH: if (phase_end) begin
                        sclk_q <= 1'b0;
                        if (bitcnt_q != 4'd0) begin
                            shreg_q  <= {shreg_q[14:0], 1'b0};
                            bitcnt_q <= bitcnt_q - 4'd1;
                            data_q   <= shreg_q[14];
                            state_q  <= LOW;
                        end
                    end
                    default: ;
                endcase
                // Load overrides the HIGH-phase update above when it fires.
                if (load_pt) begin
                    sclk_q <= 1'b0;
                    if (!d8_empty) begin
                        rd8_q    <= 1'b1;
                        shreg_q  <= {d8_data, 8'h00};
                        bitcnt_q <= 4'(BYTE_BITS - 1);
                        data_q   <= d8_data[7];
                        busy_q   <= 1'b1;
                        state_q  <= LOW;
                    end else if (!d16_empty) begin
                        rd16_q   <= 1'b1;
                        shreg_q  <= word_d;
                        bitcnt_q <= 4'(WORD_BITS - 1);
                        data_q   <= word_d[15];
                        busy_q   <= 1'b1;
                        state_q  <= LOW;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            end
        end
    end

    assign d8_read  = rd8_q;
    assign d16_read = rd16_q;
    assign lcd_busy = busy_q;
    assign lcd_sclk = sclk_q;
    assign lcd_data = data_q;

endmodule

// File: tb/tb_lcd_spi_shift_engine.sv
// Scoreboard bench for lcd_spi_shift_engine: HALF_PERIOD=2 main instance plus a
// HALF_PERIOD=1 instance. Expected MOSI bits are queued at stimulus time and
// popped by monitors on every SCLK rise.
`timescale 1ns/1ps
module tb_lcd_spi_shift_engine;

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic        rst_n, locked;
    logic        d8_empty, d8_read, d16_empty, d16_read, busy, sclk, mosi;
    logic [7:0]  d8_data;
    logic [15:0] d16_data;
    logic        b_empty, b_read, b_d16_read, b_busy, b_sclk, b_mosi;
    logic [7:0]  b_data;

    lcd_spi_shift_engine #(.HALF_PERIOD(2)) u_dut (
        .mclk(mclk), .s00_axi_aresetn(rst_n), .mclk_pll_locked(locked),
        .d8_empty(d8_empty), .d8_data(d8_data), .d8_read(d8_read),
        .d16_empty(d16_empty), .d16_data(d16_data), .d16_read(d16_read),
        .lcd_busy(busy), .lcd_sclk(sclk), .lcd_data(mosi)
    );

    lcd_spi_shift_engine #(.HALF_PERIOD(1)) u_dut_hp1 (
        .mclk(mclk), .s00_axi_aresetn(rst_n), .mclk_pll_locked(1'b1),
        .d8_empty(b_empty), .d8_data(b_data), .d8_read(b_read),
        .d16_empty(1'b1), .d16_data(16'h0000), .d16_read(b_d16_read),
        .lcd_busy(b_busy), .lcd_sclk(b_sclk), .lcd_data(b_mosi)
    );

    int n_chk = 0, n_fail = 0;
    logic [7:0]  q8[$], qb[$];
    logic [15:0] q16[$];
    bit          exp_a[$], exp_b[$];
    int          rd8_cyc[$], rd16_cyc[$], rdb_cyc[$];
    int cyc = 0, rises = 0, busy_cyc = 0, busy_starts = 0, n_rd8 = 0, n_rd16 = 0;
    int cycb = 0, rises_b = 0, busy_cyc_b = 0;
    logic p_sclk = 1'b0, p_busy = 1'b0, p_mosi = 1'b0;
    logic bp_sclk = 1'b0, bp_busy = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void refresh_a();
        d8_empty  = (q8.size() == 0);
        d8_data   = d8_empty ? 8'h00 : q8[0];
        d16_empty = (q16.size() == 0);
        d16_data  = d16_empty ? 16'h0000 : q16[0];
    endfunction

    function automatic void refresh_b();
        b_empty = (qb.size() == 0);
        b_data  = b_empty ? 8'h00 : qb[0];
    endfunction

    function automatic logic [15:0] word_exp(input logic [15:0] v);
`ifdef LCD_SPI_BYTE_SWAP_EN
        return {v[7:0], v[15:8]};
`else
        return v;
`endif
    endfunction

    // Queue the first `take` bits of an n-bit value, MSB first.
    function automatic void push_exp(input logic [15:0] v, input int n, input int take, input bit to_b);
        for (int i = 0; i < take; i++) begin
            if (to_b) exp_b.push_back(v[n-1-i]);
            else      exp_a.push_back(v[n-1-i]);
        end
    endfunction

    task automatic push8(input logic [7:0] v);
        q8.push_back(v); push_exp({8'h00, v}, 8, 8, 1'b0); refresh_a();
    endtask

    task automatic push16(input logic [15:0] v);
        q16.push_back(v); push_exp(word_exp(v), 16, 16, 1'b0); refresh_a();
    endtask

    task automatic clr();
        rises = 0; busy_cyc = 0; busy_starts = 0; n_rd8 = 0; n_rd16 = 0;
        rd8_cyc.delete(); rd16_cyc.delete();
    endtask

    task automatic wait_idle(input string name, input bit on_b);
        bit done = 0;
        repeat (2) @(negedge mclk);
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge mclk);
            if (on_b) done = !b_busy && (qb.size() == 0);
            else      done = !busy && (q8.size() == 0) && (q16.size() == 0);
        end
        check({name, "_timeout"}, {31'b0, done}, 1);
    endtask

    // Monitor for the HALF_PERIOD=2 instance; also models the two FWFT FIFOs.
    always @(posedge mclk) begin
        #1;
        cyc++;
        if (d8_read || d16_read) begin
            check("rd_excl", {31'b0, d8_read & d16_read}, 0);
            check("rd_nonempty", {31'b0, d8_read ? d8_empty : d16_empty}, 0);
            check("rd_align", {31'b0, (p_sclk & ~sclk) | (busy & ~p_busy)}, 1);
            if (d8_read) begin
                n_rd8++; rd8_cyc.push_back(cyc);
                if (q8.size() != 0) void'(q8.pop_front());
            end
            if (d16_read) begin
                n_rd16++; rd16_cyc.push_back(cyc);
                if (q16.size() != 0) void'(q16.pop_front());
            end
            refresh_a();
        end
        if (sclk && !p_sclk) begin
            rises++;
            if (exp_a.size() == 0) check("mosi_extra", 1, 0);
            else                   check("mosi", {31'b0, mosi}, {31'b0, exp_a.pop_front()});
        end
        if (busy && (mosi !== p_mosi))
            check("mosi_change_point", {31'b0, (p_sclk & ~sclk) | (busy & ~p_busy)}, 1);
        if (busy) busy_cyc++;
        if (busy && !p_busy) busy_starts++;
        p_sclk = sclk; p_busy = busy; p_mosi = mosi;
    end

    // Monitor for the HALF_PERIOD=1 instance.
    always @(posedge mclk) begin
        #1;
        cycb++;
        if (b_read || b_d16_read) begin
            check("b_rd_word", {31'b0, b_d16_read}, 0);
            check("b_rd_align", {31'b0, (bp_sclk & ~b_sclk) | (b_busy & ~bp_busy)}, 1);
            if (b_read) begin
                check("b_rd_nonempty", {31'b0, b_empty}, 0);
                rdb_cyc.push_back(cycb);
                if (qb.size() != 0) void'(qb.pop_front());
                refresh_b();
            end
        end
        if (b_sclk && !bp_sclk) begin
            rises_b++;
            if (exp_b.size() == 0) check("b_mosi_extra", 1, 0);
            else                   check("b_mosi", {31'b0, b_mosi}, {31'b0, exp_b.pop_front()});
        end
        if (b_busy) busy_cyc_b++;
        bp_sclk = b_sclk; bp_busy = b_busy;
    end

    initial begin
        bit hit;
        int bc;
        rst_n = 1'b0; locked = 1'b1;
        refresh_a(); refresh_b();
        repeat (3) @(negedge mclk);
        check("rst_sclk", {31'b0, sclk}, 0);
        check("rst_data", {31'b0, mosi}, 0);
        check("rst_reads", {30'b0, d8_read, d16_read}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_busy_b", {31'b0, b_busy}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge mclk);
        check("idle_busy", {31'b0, busy}, 0);

        // Single byte.
        clr(); push8(8'hA5); wait_idle("byte", 1'b0);
        check("byte_rises", rises, 8);
        check("byte_busy_cyc", busy_cyc, 32);
        check("byte_rd8", n_rd8, 1);
        check("byte_rd16", n_rd16, 0);

        // Two words back to back.
        clr(); push16(16'h1234); push16(16'hFFFF); wait_idle("words", 1'b0);
        check("words_rises", rises, 32);
        check("words_busy_cyc", busy_cyc, 128);
        check("words_busy_starts", busy_starts, 1);
        check("words_rd16", n_rd16, 2);
        check("words_gap", rd16_cyc.size() >= 2 ? rd16_cyc[1] - rd16_cyc[0] : -1, 64);

        // Byte arriving mid-word waits for the word to finish.
        clr(); push16(16'hF800);
        repeat (10) @(negedge mclk);
        push8(8'h2C); wait_idle("midword", 1'b0);
        check("midword_rises", rises, 24);
        check("midword_busy_cyc", busy_cyc, 96);
        check("midword_busy_starts", busy_starts, 1);
        check("midword_byte_after", (rd8_cyc.size() > 0 && rd16_cyc.size() > 0) ? rd8_cyc[0] - rd16_cyc[0] : -1, 64);

        // Both FIFOs ready in IDLE: byte first.
        clr();
        q16.push_back(16'h0000); q8.push_back(8'h36); refresh_a();
        push_exp(16'h0036, 8, 8, 1'b0); push_exp(word_exp(16'h0000), 16, 16, 1'b0);
        wait_idle("both", 1'b0);
        check("both_rises", rises, 24);
        check("both_order", (rd8_cyc.size() > 0 && rd16_cyc.size() > 0) ? rd16_cyc[0] - rd8_cyc[0] : -1, 32);

        // PLL unlock after 5 rises aborts the word.
        clr();
        q16.push_back(16'hABCD); refresh_a(); push_exp(word_exp(16'hABCD), 16, 5, 1'b0);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge mclk);
            hit = (rises == 5);
        end
        check("pll_reach_5_rises", {31'b0, hit}, 1);
        locked = 1'b0;
        @(posedge mclk); #2;
        check("pll_sclk", {31'b0, sclk}, 0);
        check("pll_busy", {31'b0, busy}, 0);
        check("pll_data", {31'b0, mosi}, 0);
        repeat (5) @(negedge mclk);
        check("pll_rises_frozen", rises, 5);
        bc = busy_cyc;
        locked = 1'b1;
        repeat (20) @(negedge mclk);
        check("relock_busy", {31'b0, busy}, 0);
        check("relock_busy_cyc", busy_cyc, bc);
        check("relock_reads", n_rd8 + n_rd16, 1);

        // HALF_PERIOD=1 with three bytes.
        qb.push_back(8'h81); qb.push_back(8'h7E); qb.push_back(8'hC3); refresh_b();
        push_exp(16'h0081, 8, 8, 1'b1); push_exp(16'h007E, 8, 8, 1'b1); push_exp(16'h00C3, 8, 8, 1'b1);
        wait_idle("hp1", 1'b1);
        check("hp1_rises", rises_b, 24);
        check("hp1_busy_cyc", busy_cyc_b, 48);
        check("hp1_reads", rdb_cyc.size(), 3);
        check("hp1_gap0", rdb_cyc.size() >= 3 ? rdb_cyc[1] - rdb_cyc[0] : -1, 16);
        check("hp1_gap1", rdb_cyc.size() >= 3 ? rdb_cyc[2] - rdb_cyc[1] : -1, 16);

        check("exp_a_drained", exp_a.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
